// File: rtl/space_invaders_pkg.sv
// Shared types and sizes for the invader formation logic.
// Imported by the swarm controller and its popcount helper.
package space_invaders_pkg;

    localparam int NUM_INVADERS = 20;
    localparam int IDX_W        = 5;

    typedef enum logic [1:0] {
        GS_BEGIN    = 2'b00,
        GS_CONT     = 2'b01,
        GS_WIN      = 2'b10,
        GS_GAMEOVER = 2'b11
    } game_state_t;

    typedef enum logic [1:0] {
        SW_IDLE,
        SW_MARCH,
        SW_STEP_DOWN,
        SW_HALT
    } swarm_state_t;

endpackage

// File: rtl/invader_popcount.sv
// Combinational count of alive invaders in the formation mask.
// Result is registered by the swarm controller.
module invader_popcount
    import space_invaders_pkg::*;
(
    input  logic [NUM_INVADERS-1:0] mask,
    output logic [IDX_W-1:0]        count
);

    // Sum the alive bits one by one.
    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_INVADERS; i++) begin
            count = count + IDX_W'(mask[i]);
        end
    end

endmodule

// File: rtl/invader_swarm_ctrl.sv
// Invader formation controller: alive mask, march, descent, speed.
// Resolves bullet hits and reports position to game FSM and renderer.
module invader_swarm_ctrl
    import space_invaders_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 5,
    parameter int X_SPAN         = 10,
    parameter int LINE_MAX       = 14,
    parameter int PERIOD_MIN     = 4,
    parameter int PERIOD_PER_INV = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              game_state,
    input  logic                    hit_valid,
    input  logic [IDX_W-1:0]        hit_idx,
    output logic                    hit_ack,
    output logic                    hit_miss,
    output logic [NUM_INVADERS-1:0] invaders_left,
    output logic [IDX_W-1:0]        alive_count,
    output logic [3:0]              invader_line,
    output logic [3:0]              x_pos,
    output logic                    dir,
    output logic                    step_pulse
);

    localparam logic [NUM_INVADERS-1:0] FULL_MASK =
        NUM_INVADERS'((64'd1 << (ROWS * COLS)) - 64'd1);

    game_state_t             gs;
    swarm_state_t            state_q;
    swarm_state_t            state_d;
    logic [NUM_INVADERS-1:0] mask_d;
    logic [NUM_INVADERS-1:0] hit_oh;
    logic [IDX_W-1:0]        pop;
    logic [IDX_W-1:0]        count_d;
    logic [3:0]              line_d;
    logic [3:0]              x_d;
    logic                    dir_d;
    logic                    step_d;
    logic                    ack_d;
    logic                    miss_d;
    logic [6:0]              cnt_q;
    logic [6:0]              cnt_d;
    logic [6:0]              period_last;
    logic                    at_wall;
    logic                    hit_live;
    logic                    hit_take;

    invader_popcount u_pop (
        .mask  (invaders_left),
        .count (pop)
    );

    assign gs = game_state_t'(game_state);

    // Out-of-range indices shift the one-hot out entirely.
    assign hit_oh = NUM_INVADERS'(1) << hit_idx;

    assign period_last = 7'(PERIOD_MIN)
                       + 7'(PERIOD_PER_INV) * 7'(alive_count)
                       - 7'd1;

    assign at_wall = dir ? (x_pos == 4'(X_SPAN))
                         : (x_pos == 4'd0);

    assign hit_live = (gs == GS_CONT) &&
                      ((state_q == SW_MARCH) ||
                       (state_q == SW_STEP_DOWN));

    assign hit_take = hit_valid && hit_live &&
                      (|(invaders_left & hit_oh));

    // Next-state, march timing and hit resolution.
    always_comb begin
        state_d = state_q;
        mask_d  = invaders_left;
        count_d = alive_count;
        line_d  = invader_line;
        x_d     = x_pos;
        dir_d   = dir;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        ack_d   = hit_take;
        miss_d  = hit_valid && !hit_take;
        unique case (gs)
            GS_BEGIN: begin
                state_d = SW_IDLE;
                mask_d  = FULL_MASK;
                count_d = IDX_W'(NUM_INVADERS);
                line_d  = 4'd0;
                x_d     = 4'd0;
                dir_d   = 1'b1;
                cnt_d   = '0;
            end
            GS_WIN, GS_GAMEOVER: begin
                state_d = SW_HALT;
            end
            GS_CONT: begin
                count_d = pop;
                if (hit_take) begin
                    mask_d = invaders_left & ~hit_oh;
                end
                unique case (state_q)
                    SW_IDLE, SW_HALT: begin
                        state_d = SW_MARCH;
                        cnt_d   = '0;
                    end
                    SW_STEP_DOWN: begin
                        state_d = SW_MARCH;
                        dir_d   = ~dir;
                        step_d  = 1'b1;
                        cnt_d   = '0;
                        if (invader_line < 4'(LINE_MAX)) begin
                            line_d = invader_line + 4'd1;
                        end else begin
                            line_d = 4'(LINE_MAX);
                        end
                    end
                    SW_MARCH: begin
                        if (alive_count == '0) begin
                            cnt_d = '0;
                        end else if (cnt_q >= period_last) begin
                            cnt_d  = '0;
                            step_d = 1'b1;
                            if (at_wall) begin
                                state_d = SW_STEP_DOWN;
                            end else if (dir) begin
                                x_d = x_pos + 4'd1;
                            end else begin
                                x_d = x_pos - 4'd1;
                            end
                        end else begin
                            cnt_d = cnt_q + 7'd1;
                        end
                    end
                endcase
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= SW_IDLE;
            invaders_left <= FULL_MASK;
            alive_count   <= IDX_W'(NUM_INVADERS);
            invader_line  <= 4'd0;
            x_pos         <= 4'd0;
            dir           <= 1'b1;
            cnt_q         <= '0;
            step_pulse    <= 1'b0;
            hit_ack       <= 1'b0;
            hit_miss      <= 1'b0;
        end else begin
            state_q       <= state_d;
            invaders_left <= mask_d;
            alive_count   <= count_d;
            invader_line  <= line_d;
            x_pos         <= x_d;
            dir           <= dir_d;
            cnt_q         <= cnt_d;
            step_pulse    <= step_d;
            hit_ack       <= ack_d;
            hit_miss      <= miss_d;
        end
    end

endmodule

// File: tb/tb_invader_swarm_ctrl.sv
// Bench for invader_swarm_ctrl: directed steps plus random hits and
// game-state changes, checked every cycle against a behavioural model.
module tb_invader_swarm_ctrl;

    localparam logic [1:0] G_BEGIN = 2'b00;
    localparam logic [1:0] G_CONT  = 2'b01;
    localparam logic [1:0] G_WIN   = 2'b10;
    localparam logic [1:0] G_OVER  = 2'b11;

    localparam int M_IDLE  = 0;
    localparam int M_MARCH = 1;
    localparam int M_DROP  = 2;
    localparam int M_HALT  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  game_state;
    logic        hit_valid;
    logic [4:0]  hit_idx;
    logic        hit_ack;
    logic        hit_miss;
    logic [19:0] invaders_left;
    logic [4:0]  alive_count;
    logic [3:0]  invader_line;
    logic [3:0]  x_pos;
    logic        dir;
    logic        step_pulse;

    int vectors = 0;
    int errs    = 0;

    bit [19:0] m_mask;
    int        m_cnt;
    int        m_line;
    int        m_x;
    bit        m_dir;
    int        m_timer;
    int        m_mode;
    bit        m_step;
    bit        m_ack;
    bit        m_miss;

    int        np;
    int        pt[16];
    int        px[16];
    int        pl[16];
    bit        pd[16];
    int        nsteps;
    logic [19:0] snap_mask;
    logic [3:0]  snap_x;
    logic [3:0]  snap_line;
    logic        snap_dir;

    always #5 clk = ~clk;

    invader_swarm_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .game_state    (game_state),
        .hit_valid     (hit_valid),
        .hit_idx       (hit_idx),
        .hit_ack       (hit_ack),
        .hit_miss      (hit_miss),
        .invaders_left (invaders_left),
        .alive_count   (alive_count),
        .invader_line  (invader_line),
        .x_pos         (x_pos),
        .dir           (dir),
        .step_pulse    (step_pulse)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, got, exp);
        end
    endtask

    task automatic model_reload();
        m_mask  = 20'hFFFFF;
        m_cnt   = 20;
        m_line  = 0;
        m_x     = 0;
        m_dir   = 1'b1;
        m_timer = 0;
        m_mode  = M_IDLE;
    endtask

    task automatic model_reset();
        model_reload();
        m_step = 1'b0;
        m_ack  = 1'b0;
        m_miss = 1'b0;
    endtask

    task automatic model_edge(input logic [1:0] g,
                              input bit hv, input int idx);
        int old_pop;
        old_pop = $countones(m_mask);
        m_step = 1'b0;
        m_ack  = 1'b0;
        m_miss = 1'b0;
        if (g == G_BEGIN) begin
            model_reload();
            m_miss = hv;
        end else if (g != G_CONT) begin
            m_mode = M_HALT;
            m_miss = hv;
        end else begin
            if (hv) begin
                if ((m_mode == M_MARCH || m_mode == M_DROP) &&
                    idx < 20 && m_mask[idx]) begin
                    m_mask[idx] = 1'b0;
                    m_ack = 1'b1;
                end else begin
                    m_miss = 1'b1;
                end
            end
            if (m_mode == M_IDLE || m_mode == M_HALT) begin
                m_mode  = M_MARCH;
                m_timer = 0;
            end else if (m_mode == M_DROP) begin
                m_dir   = !m_dir;
                m_line  = (m_line + 1 > 14) ? 14 : m_line + 1;
                m_step  = 1'b1;
                m_mode  = M_MARCH;
                m_timer = 0;
            end else if (m_cnt == 0) begin
                m_timer = 0;
            end else if (m_timer + 1 >= 4 + 2 * m_cnt) begin
                m_timer = 0;
                m_step  = 1'b1;
                if ((m_dir && m_x == 10) || (!m_dir && m_x == 0))
                    m_mode = M_DROP;
                else
                    m_x = m_x + (m_dir ? 1 : -1);
            end else begin
                m_timer++;
            end
            m_cnt = old_pop;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".mask"}, 32'(invaders_left), 32'(m_mask));
        check({tag, ".count"}, 32'(alive_count), m_cnt);
        check({tag, ".line"}, 32'(invader_line), m_line);
        check({tag, ".x"}, 32'(x_pos), m_x);
        check({tag, ".dir"}, 32'(dir), 32'(m_dir));
        check({tag, ".step"}, 32'(step_pulse), 32'(m_step));
        check({tag, ".ack"}, 32'(hit_ack), 32'(m_ack));
        check({tag, ".miss"}, 32'(hit_miss), 32'(m_miss));
    endtask

    task automatic tick(input logic [1:0] g, input bit hv,
                        input int idx, input string tag);
        game_state = g;
        hit_valid  = hv;
        hit_idx    = 5'(idx);
        @(posedge clk);
        model_edge(g, hv, idx);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset      = 1'b0;
        game_state = G_BEGIN;
        hit_valid  = 1'b0;
        hit_idx    = 5'd0;
        model_reset();
        #12;
        check_all("rst");
        check("rst.mask_k", 32'(invaders_left), 32'hFFFFF);
        check("rst.count_k", 32'(alive_count), 20);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick(G_BEGIN, 0, 0, "begin");

        // Clean march: period 44, ten moves, wall pulse, drop pulse.
        np = 0;
        for (int c = 0; c < 700 && np < 12; c++) begin
            tick(G_CONT, 0, 0, "march");
            if (step_pulse) begin
                pt[np] = c;
                px[np] = int'(x_pos);
                pl[np] = int'(invader_line);
                pd[np] = dir;
                np++;
            end
        end
        check("npulse", np, 12);
        check("gap44", pt[1] - pt[0], 44);
        check("x_first", px[0], 1);
        check("x_at10", px[9], 10);
        check("gap_wall", pt[10] - pt[9], 44);
        check("gap_drop", pt[11] - pt[10], 1);
        check("line1", pl[11], 1);
        check("dir0", 32'(pd[11]), 0);

        // Single kill, repeat kill, out-of-range index.
        tick(G_CONT, 1, 7, "hit7");
        check("ack7", 32'(hit_ack), 1);
        check("bit7", 32'(invaders_left[7]), 0);
        tick(G_CONT, 0, 0, "hit7b");
        check("cnt19", 32'(alive_count), 19);
        tick(G_CONT, 1, 7, "rehit7");
        check("miss7", 32'(hit_miss), 1);
        snap_mask = invaders_left;
        tick(G_CONT, 1, 25, "hit25");
        check("miss25", 32'(hit_miss), 1);
        check("mask25", 32'(invaders_left), 32'(snap_mask));

        // Game over freezes everything; hits miss.
        tick(G_OVER, 0, 0, "over");
        snap_mask = invaders_left;
        snap_x    = x_pos;
        snap_line = invader_line;
        snap_dir  = dir;
        for (int i = 0; i < 60; i++)
            tick(G_OVER, 1, i % 20, "halt");
        check("halt.mask", 32'(invaders_left), 32'(snap_mask));
        check("halt.x", 32'(x_pos), 32'(snap_x));
        check("halt.line", 32'(invader_line), 32'(snap_line));
        check("halt.dir", 32'(dir), 32'(snap_dir));
        check("halt.miss", 32'(hit_miss), 1);

        // Leave one invader so the swarm runs fast to the bottom.
        tick(G_CONT, 0, 0, "resume");
        for (int i = 0; i < 19; i++)
            if (i != 7) tick(G_CONT, 1, i, "thin");
        for (int i = 0; i < 2000; i++) tick(G_CONT, 0, 0, "descend");
        check("line_sat", 32'(invader_line), 14);

        // Random hits and state changes.
        tick(G_BEGIN, 1, 3, "idlehit");
        check("idle.miss", 32'(hit_miss), 1);
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [1:0] g;
            r = int'($urandom_range(0, 99));
            if (r < 2)      g = G_BEGIN;
            else if (r < 4) g = G_WIN;
            else if (r < 6) g = G_OVER;
            else            g = G_CONT;
            tick(g, ($urandom_range(0, 9) < 3),
                 int'($urandom_range(0, 24)), "rand");
        end

        // Reload, then kill the whole swarm.
        tick(G_BEGIN, 0, 0, "reload");
        tick(G_BEGIN, 0, 0, "reload");
        check("rl.mask", 32'(invaders_left), 32'hFFFFF);
        check("rl.count", 32'(alive_count), 20);
        check("rl.line", 32'(invader_line), 0);
        check("rl.x", 32'(x_pos), 0);
        check("rl.dir", 32'(dir), 1);
        tick(G_CONT, 0, 0, "go");
        for (int i = 0; i < 20; i++) tick(G_CONT, 1, 19 - i, "kill");
        for (int i = 0; i < 3; i++) tick(G_CONT, 0, 0, "settle");
        check("dead.count", 32'(alive_count), 0);
        check("dead.mask", 32'(invaders_left), 0);
        nsteps = 0;
        for (int i = 0; i < 200; i++) begin
            tick(G_CONT, 0, 0, "dead");
            if (step_pulse) nsteps++;
        end
        check("dead.steps", nsteps, 0);
        tick(G_BEGIN, 0, 0, "revive");
        check("rv.mask", 32'(invaders_left), 32'hFFFFF);

        // Asynchronous reset in the middle of a march.
        for (int i = 0; i < 120; i++)
            tick(G_CONT, (i % 17 == 0), i % 20, "prerst");
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("midrst");
        check("midrst.x", 32'(x_pos), 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        tick(G_BEGIN, 0, 0, "post");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errs);
        $finish;
    end

endmodule
